// File: rtl/mem_stage_if.sv
// Pipeline-side memory access bus: load/store strobes, byte address, store data and load data.
// Read_data is driven combinationally by the memory stage within the cycle.
interface mem_stage_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport master (
    output MemRead, MemWrite, addr, Write_data,
    input  Read_data
  );

  modport slave (
    input  MemRead, MemWrite, addr, Write_data,
    output Read_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: word RAM plus timer/LED/7-seg/systick peripherals behind an address decode.
// Loads are combinational (0 cycles); stores and timer updates land on the next rising edge.
module mem_stage #(
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic          clk,
  input  logic          reset,
  mem_stage_if.slave    bus,
  output logic [7:0]    leds,
  output logic [11:0]   digits,
  output logic          irq
);

  localparam int          AW      = $clog2(RAM_WORDS);
  localparam logic [29:0] RAM_LIM = 30'(RAM_WORDS);
  localparam logic [29:0] P_WORD  = PERIPH_BASE[31:2];

  logic [29:0]   waddr;
  logic [29:0]   poff;
  logic [2:0]    psel;
  logic          in_ram;
  logic          in_periph;
  logic [AW-1:0] ram_idx;
  logic [1:0]    unused_lsb;

  logic [31:0] th, tl, systick;
  logic [2:0]  tcon;
  logic [7:0]  led_q;
  logic [11:0] dig_q;
  logic [31:0] ram [RAM_WORDS];

  logic wr_ram, wr_th, wr_tl, wr_tcon, wr_led, wr_dig;
  logic ovf;
  logic [31:0] rdata;

  // Byte lanes are not supported, so the low address bits carry no information.
  assign unused_lsb = bus.addr[1:0];
  assign waddr      = bus.addr[31:2];
  assign poff       = waddr - P_WORD;
  assign psel       = poff[2:0];
  assign in_ram     = waddr < RAM_LIM;
  assign in_periph  = poff < 30'd6;
  assign ram_idx    = bus.addr[AW+1:2];

  assign wr_ram  = bus.MemWrite && in_ram;
  assign wr_th   = bus.MemWrite && in_periph && (psel == 3'd0);
  assign wr_tl   = bus.MemWrite && in_periph && (psel == 3'd1);
  assign wr_tcon = bus.MemWrite && in_periph && (psel == 3'd2);
  assign wr_led  = bus.MemWrite && in_periph && (psel == 3'd3);
  assign wr_dig  = bus.MemWrite && in_periph && (psel == 3'd4);

  assign ovf = tcon[0] && (tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= bus.Write_data;
  end

  // Software stores take priority over the timer's own update in the same cycle;
  // the reload samples the pre-edge TH, so a concurrent TH store applies next overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led_q   <= '0;
      dig_q   <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr_th) th <= bus.Write_data;
      if (wr_tl)        tl <= bus.Write_data;
      else if (ovf)     tl <= th;
      else if (tcon[0]) tl <= tl + 32'd1;
      if (wr_tcon)                tcon    <= bus.Write_data[2:0];
      else if (ovf && tcon[1])    tcon[2] <= 1'b1;
      if (wr_led) led_q <= bus.Write_data[7:0];
      if (wr_dig) dig_q <= bus.Write_data[11:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.MemRead) begin
      if (in_ram) begin
        rdata = ram[ram_idx];
      end else if (in_periph) begin
        case (psel)
          3'd0:    rdata = th;
          3'd1:    rdata = tl;
          3'd2:    rdata = {29'b0, tcon};
          3'd3:    rdata = {24'b0, led_q};
          3'd4:    rdata = {20'b0, dig_q};
          3'd5:    rdata = systick;
          default: rdata = '0;
        endcase
      end
    end
  end

  assign bus.Read_data = rdata;
  assign leds          = led_q;
  assign digits        = dig_q;
  assign irq           = tcon[2];

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected load data is queued at stimulus time and checked on output.
module tb_mem_stage;
  localparam logic [31:0] P       = 32'h4000_0000;
  localparam logic [31:0] A_TH    = P + 32'h00;
  localparam logic [31:0] A_TL    = P + 32'h04;
  localparam logic [31:0] A_TCON  = P + 32'h08;
  localparam logic [31:0] A_LED   = P + 32'h0C;
  localparam logic [31:0] A_DIG   = P + 32'h10;
  localparam logic [31:0] A_SYS   = P + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;
  logic [31:0] tb_tick;
  logic [31:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage #(.RAM_WORDS(256), .PERIPH_BASE(32'h4000_0000)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .leds   (leds),
    .digits (digits),
    .irq    (irq)
  );

  // Reference count of rising edges since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_tick <= '0;
    else        tb_tick <= tb_tick + 32'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b1;
    bus.addr       = a;
    bus.Write_data = d;
    @(posedge clk);
    #1;
    bus.MemWrite   = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    bus.addr     = a;
    #1;
    d = bus.Read_data;
    bus.MemRead  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a_tab [6];
    logic [31:0] got, exp;
    a_tab = '{A_TCON, A_TL, A_TH, A_LED, A_DIG, A_SYS};
    #23;
    vectors++;
    if ({leds, digits, irq} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs leds=%h digits=%h irq=%b required all 0", leds, digits, irq);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'd0);
      load(a_tab[i], got);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_load addr=%h got=%h required=%h", a_tab[i], got, exp);
      end
    end
  endtask

  task automatic test_ram();
    logic [31:0] a_tab [5];
    logic [31:0] got, exp;
    store(32'h10, 32'hDEAD_BEEF);
    store(32'h0, 32'hCAFE_0000);
    store(32'h3FC, 32'h5555_AAAA);
    store(32'h400, 32'h1234_5678);
    store(32'h4000_0018, 32'h7777_7777);
    a_tab = '{32'h10, 32'h13, 32'h400, 32'h0, 32'h3FC};
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hCAFE_0000);
    exp_q.push_back(32'h5555_AAAA);
    for (int i = 0; i < 5; i++) begin
      load(a_tab[i], got);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL ram_load addr=%h got=%h required=%h", a_tab[i], got, exp);
      end
    end
    step();
    exp_q.push_back(32'h0);
    load(32'h4000_0018, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL unmapped_load got=%h required=%h", got, exp);
    end
    bus.addr = 32'h10;
    #1;
    vectors++;
    if (bus.Read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL idle_read_data got=%h required=0", bus.Read_data);
    end
  endtask

  task automatic test_periph();
    logic [31:0] got, exp;
    step();
    store(A_LED, 32'h0000_01A5);
    store(A_DIG, 32'hFFFF_F123);
    vectors++;
    if (leds !== 8'hA5 || digits !== 12'h123) begin
      miscompares++;
      $display("FAIL periph_outputs leds=%h digits=%h required a5/123", leds, digits);
    end
    exp_q.push_back(32'h0000_00A5);
    load(A_LED, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL led_read got=%h required=%h", got, exp);
    end
    exp_q.push_back(32'h0000_0123);
    load(A_DIG, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL digits_read got=%h required=%h", got, exp);
    end
    store(A_SYS, 32'h0);
    exp_q.push_back(tb_tick);
    load(A_SYS, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL systick got=%h required=%h", got, exp);
    end
  endtask

  task automatic test_timer();
    logic [31:0] tl_tab [7];
    logic        irq_tab [7];
    logic [31:0] got, exp;
    tl_tab  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFD,
                32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    irq_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    step();
    store(A_TH, 32'hFFFF_FFFC);
    store(A_TL, 32'hFFFF_FFFE);
    store(A_TCON, 32'h3);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      exp_q.push_back(tl_tab[i]);
      load(A_TL, got);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp || irq !== irq_tab[i]) begin
        miscompares++;
        $display("FAIL timer_cycle%0d tl=%h irq=%b required tl=%h irq=%b",
                 i, got, irq, exp, irq_tab[i]);
      end
    end
    store(A_TCON, 32'h3);
    exp_q.push_back(32'h3);
    load(A_TCON, got);
    exp = exp_q.pop_front();
    vectors++;
    if (irq !== 1'b0 || got !== exp) begin
      miscompares++;
      $display("FAIL timer_irq_clear irq=%b tcon=%h required irq=0 tcon=%h", irq, got, exp);
    end
  endtask

  task automatic test_collisions();
    logic [31:0] got, exp;
    store(A_TCON, 32'h1);
    store(A_TH, 32'h100);
    store(A_TL, 32'h5);
    exp_q.push_back(32'h5);
    load(A_TL, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL tl_store_wins got=%h required=%h", got, exp);
    end
    step();
    exp_q.push_back(32'h6);
    load(A_TL, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL tl_after_store got=%h required=%h", got, exp);
    end
    store(A_TCON, 32'h3);
    store(A_TL, 32'hFFFF_FFFF);
    store(A_TCON, 32'h3);
    exp_q.push_back(32'h100);
    load(A_TL, got);
    exp = exp_q.pop_front();
    vectors++;
    if (irq !== 1'b0 || got !== exp) begin
      miscompares++;
      $display("FAIL tcon_store_wins irq=%b tl=%h required irq=0 tl=%h", irq, got, exp);
    end
    store(A_TL, 32'hFFFF_FFFF);
    store(A_TH, 32'h200);
    exp_q.push_back(32'h100);
    load(A_TL, got);
    exp = exp_q.pop_front();
    vectors++;
    if (irq !== 1'b1 || got !== exp) begin
      miscompares++;
      $display("FAIL th_store_old_reload irq=%b tl=%h required irq=1 tl=%h", irq, got, exp);
    end
    store(A_TL, 32'hFFFF_FFFF);
    step();
    exp_q.push_back(32'h200);
    load(A_TL, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL th_new_reload got=%h required=%h", got, exp);
    end
    store(A_TCON, 32'h0);
  endtask

  task automatic test_rdwr();
    logic [31:0] got, exp;
    store(32'h20, 32'h1);
    exp_q.push_back(32'h1);
    bus.MemRead    = 1'b1;
    bus.MemWrite   = 1'b1;
    bus.addr       = 32'h20;
    bus.Write_data = 32'h2;
    #1;
    got = bus.Read_data;
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL rdwr_old_value got=%h required=%h", got, exp);
    end
    @(posedge clk);
    #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    exp_q.push_back(32'h2);
    load(32'h20, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL rdwr_new_value got=%h required=%h", got, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] got, exp;
    store(A_TCON, 32'h7);
    store(A_LED, 32'hA5);
    vectors++;
    if (leds !== 8'hA5 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_state leds=%h irq=%b required a5/1", leds, irq);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (leds !== 8'h00 || irq !== 1'b0 || digits !== 12'h000) begin
      miscompares++;
      $display("FAIL async_reset_outputs leds=%h irq=%b digits=%h required 0", leds, irq, digits);
    end
    exp_q.push_back(32'h0);
    load(A_TL, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL async_reset_tl got=%h required=%h", got, exp);
    end
    exp_q.push_back(32'hDEAD_BEEF);
    load(32'h10, got);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL ram_survives_reset got=%h required=%h", got, exp);
    end
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.addr       = '0;
    bus.Write_data = '0;
    test_reset();
    test_ram();
    test_periph();
    test_timer();
    test_collisions();
    test_rdwr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
